// File: rtl/otter_ctrl_pipe_if.sv
// Bundle of decoder inputs and pipeline/hazard outputs for otter_ctrl_pipe.
// The slave side is the control pipe itself; the master side is whoever
// drives the ID-stage decode results and consumes the hazard responses.
interface otter_ctrl_pipe_if;
   logic        id_valid;
   logic [19:0] id_ctrl;
   logic        id_branch;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_rs1_used;
   logic        id_rs2_used;
   logic [4:0]  id_rd;
   logic        ex_branch_taken;

   logic        ex_valid;
   logic        mem_valid;
   logic        wb_valid;
   logic [19:0] ex_ctrl;
   logic [19:0] mem_ctrl;
   logic [19:0] wb_ctrl;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [4:0]  mem_rd;
   logic [4:0]  wb_rd;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic        stall;
   logic        flush;
   logic [2:0]  pc_sel;

   modport master (
      output id_valid, id_ctrl, id_branch, id_rs1, id_rs2,
             id_rs1_used, id_rs2_used, id_rd, ex_branch_taken,
      input  ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
             ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
             fwd_a, fwd_b, stall, flush, pc_sel
   );

   modport slave (
      input  id_valid, id_ctrl, id_branch, id_rs1, id_rs2,
             id_rs1_used, id_rs2_used, id_rd, ex_branch_taken,
      output ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
             ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
             fwd_a, fwd_b, stall, flush, pc_sel
   );
endinterface

// File: rtl/otter_ctrl_pipe.sv
// Control-word carrier for the EX/MEM/WB pipeline registers of the OTTER
// RV32I core, plus the hazard unit: load-use stall, EX operand forwarding
// and PC redirect/flush for taken branches, jumps and mret.
module otter_ctrl_pipe (
   input  logic               CLK,
   input  logic               RST,
   otter_ctrl_pipe_if.slave   bus
);

   // Bit positions inside the 20-bit control word
   localparam int REG_WRITE = 8;
   localparam int MEM_RD_EN = 6;
   localparam int MRET_EX   = 4;
   localparam int JUMP      = 3;

   logic        ex_valid_q, mem_valid_q, wb_valid_q;
   logic [19:0] ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
   logic        ex_branch_q;
   logic [4:0]  ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;

   logic        redirect;
   logic        load_hazard;
   logic        stall;
   logic        bubble;
   logic [2:0]  pc_sel;
   logic [1:0]  fwd_a, fwd_b;

   // Redirect on EX jump/mret/taken branch; load-use stall is suppressed
   // when redirecting because the ID instruction is then wrong-path.
   always_comb begin
      redirect    = ex_valid_q & (ex_ctrl_q[JUMP] | ex_ctrl_q[MRET_EX] |
                                  (ex_branch_q & bus.ex_branch_taken));
      pc_sel      = 3'b000;
      if (redirect) begin
         if (ex_ctrl_q[MRET_EX])
            pc_sel = 3'b101;
         else if (ex_ctrl_q[JUMP])
            pc_sel = ex_ctrl_q[2:0];
         else
            pc_sel = 3'b010;
      end
      load_hazard = bus.id_valid & ex_valid_q & ex_ctrl_q[MEM_RD_EN] &
                    (ex_rd_q != 5'd0) &
                    ((bus.id_rs1_used & (bus.id_rs1 == ex_rd_q)) |
                     (bus.id_rs2_used & (bus.id_rs2 == ex_rd_q)));
      stall       = load_hazard & ~redirect;
      bubble      = stall | redirect;
   end

   // Forward selects: MEM result beats WB result; x0 and EX bubbles never forward.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (ex_valid_q) begin
         if (wb_valid_q & wb_ctrl_q[REG_WRITE] & (wb_rd_q != 5'd0) & (wb_rd_q == ex_rs1_q))
            fwd_a = 2'b10;
         if (mem_valid_q & mem_ctrl_q[REG_WRITE] & (mem_rd_q != 5'd0) & (mem_rd_q == ex_rs1_q))
            fwd_a = 2'b01;
         if (wb_valid_q & wb_ctrl_q[REG_WRITE] & (wb_rd_q != 5'd0) & (wb_rd_q == ex_rs2_q))
            fwd_b = 2'b10;
         if (mem_valid_q & mem_ctrl_q[REG_WRITE] & (mem_rd_q != 5'd0) & (mem_rd_q == ex_rs2_q))
            fwd_b = 2'b01;
      end
   end

   // EX takes the ID word, or a bubble on stall/flush.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= 20'd0;
         ex_branch_q <= 1'b0;
         ex_rs1_q    <= 5'd0;
         ex_rs2_q    <= 5'd0;
         ex_rd_q     <= 5'd0;
      end else if (bubble) begin
         ex_valid_q  <= 1'b0;
         ex_ctrl_q   <= 20'd0;
         ex_branch_q <= 1'b0;
         ex_rs1_q    <= 5'd0;
         ex_rs2_q    <= 5'd0;
         ex_rd_q     <= 5'd0;
      end else begin
         ex_valid_q  <= bus.id_valid;
         ex_ctrl_q   <= bus.id_ctrl;
         ex_branch_q <= bus.id_branch;
         ex_rs1_q    <= bus.id_rs1;
         ex_rs2_q    <= bus.id_rs2;
         ex_rd_q     <= bus.id_rd;
      end
   end

   // MEM and WB always advance; the back end of the pipe never stalls.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mem_valid_q <= 1'b0;
         mem_ctrl_q  <= 20'd0;
         mem_rd_q    <= 5'd0;
         wb_valid_q  <= 1'b0;
         wb_ctrl_q   <= 20'd0;
         wb_rd_q     <= 5'd0;
      end else begin
         mem_valid_q <= ex_valid_q;
         mem_ctrl_q  <= ex_ctrl_q;
         mem_rd_q    <= ex_rd_q;
         wb_valid_q  <= mem_valid_q;
         wb_ctrl_q   <= mem_ctrl_q;
         wb_rd_q     <= mem_rd_q;
      end
   end

   assign bus.ex_valid  = ex_valid_q;
   assign bus.mem_valid = mem_valid_q;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.ex_ctrl   = ex_ctrl_q;
   assign bus.mem_ctrl  = mem_ctrl_q;
   assign bus.wb_ctrl   = wb_ctrl_q;
   assign bus.ex_rs1    = ex_rs1_q;
   assign bus.ex_rs2    = ex_rs2_q;
   assign bus.ex_rd     = ex_rd_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.fwd_a     = fwd_a;
   assign bus.fwd_b     = fwd_b;
   assign bus.stall     = stall;
   assign bus.flush     = redirect;
   assign bus.pc_sel    = pc_sel;

endmodule

// File: tb/tb_otter_ctrl_pipe.sv
// Testbench for otter_ctrl_pipe: directed hazard scenarios followed by a
// randomized run, all checked against a stage-list model of the pipeline.
module tb_otter_ctrl_pipe;

   localparam logic [19:0] W_ADD  = 20'h00100;
   localparam logic [19:0] W_LW   = 20'h00540;
   localparam logic [19:0] W_JAL  = 20'h0010B;
   localparam logic [19:0] W_JALR = 20'h00109;
   localparam logic [19:0] W_MRET = 20'h00010;
   localparam logic [19:0] W_BR   = 20'h00002;

   typedef struct {
      logic        valid;
      logic [19:0] ctrl;
      logic        branch;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } stage_t;

   logic clk;
   logic rst;
   otter_ctrl_pipe_if bus ();

   otter_ctrl_pipe dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // Model stages: index 0 = EX, 1 = MEM, 2 = WB
   stage_t      mdl [3];
   int          tests;
   int          failed;
   logic        exp_flush;
   logic        exp_stall;
   logic [2:0]  exp_pc_sel;
   logic [1:0]  exp_fwd_a;
   logic [1:0]  exp_fwd_b;

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         failed++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic stage_t emptyStage();
      stage_t s;
      s.valid = 1'b0; s.ctrl = 20'd0; s.branch = 1'b0;
      s.rs1 = 5'd0; s.rs2 = 5'd0; s.rd = 5'd0;
      return s;
   endfunction

   // Which later stage (1 = MEM, 2 = WB) supplies register r, nearest first
   function automatic logic [1:0] forwardFrom(input logic [4:0] r);
      if (!mdl[0].valid || r == 5'd0) return 2'd0;
      for (int s = 1; s <= 2; s++)
         if (mdl[s].valid && mdl[s].ctrl[8] && mdl[s].rd == r)
            return 2'(s);
      return 2'd0;
   endfunction

   task automatic computeExpected();
      logic [4:0] load_dest;
      logic       hazard;
      exp_pc_sel = 3'b000;
      exp_flush  = 1'b0;
      if (mdl[0].valid) begin
         if (mdl[0].ctrl[4]) begin
            exp_flush = 1'b1; exp_pc_sel = 3'b101;
         end else if (mdl[0].ctrl[3]) begin
            exp_flush = 1'b1; exp_pc_sel = mdl[0].ctrl[2:0];
         end else if (mdl[0].branch && bus.ex_branch_taken) begin
            exp_flush = 1'b1; exp_pc_sel = 3'b010;
         end
      end
      load_dest = (mdl[0].valid && mdl[0].ctrl[6]) ? mdl[0].rd : 5'd0;
      hazard = bus.id_valid && load_dest != 5'd0 &&
               ((bus.id_rs1_used && bus.id_rs1 == load_dest) ||
                (bus.id_rs2_used && bus.id_rs2 == load_dest));
      exp_stall = hazard && !exp_flush;
      exp_fwd_a = forwardFrom(mdl[0].rs1);
      exp_fwd_b = forwardFrom(mdl[0].rs2);
   endtask

   task automatic checkAgainstModel();
      computeExpected();
      checkOutput("ex_valid",  32'(bus.ex_valid),  32'(mdl[0].valid));
      checkOutput("mem_valid", 32'(bus.mem_valid), 32'(mdl[1].valid));
      checkOutput("wb_valid",  32'(bus.wb_valid),  32'(mdl[2].valid));
      checkOutput("ex_ctrl",   32'(bus.ex_ctrl),   32'(mdl[0].ctrl));
      checkOutput("mem_ctrl",  32'(bus.mem_ctrl),  32'(mdl[1].ctrl));
      checkOutput("wb_ctrl",   32'(bus.wb_ctrl),   32'(mdl[2].ctrl));
      checkOutput("ex_rs1",    32'(bus.ex_rs1),    32'(mdl[0].rs1));
      checkOutput("ex_rs2",    32'(bus.ex_rs2),    32'(mdl[0].rs2));
      checkOutput("ex_rd",     32'(bus.ex_rd),     32'(mdl[0].rd));
      checkOutput("mem_rd",    32'(bus.mem_rd),    32'(mdl[1].rd));
      checkOutput("wb_rd",     32'(bus.wb_rd),     32'(mdl[2].rd));
      checkOutput("fwd_a",     32'(bus.fwd_a),     32'(exp_fwd_a));
      checkOutput("fwd_b",     32'(bus.fwd_b),     32'(exp_fwd_b));
      checkOutput("stall",     32'(bus.stall),     32'(exp_stall));
      checkOutput("flush",     32'(bus.flush),     32'(exp_flush));
      checkOutput("pc_sel",    32'(bus.pc_sel),    32'(exp_pc_sel));
   endtask

   // Drive one ID word (called just after a falling edge), then check the model
   task automatic applyStimulus(input logic valid, input logic [19:0] ctrl,
                                input logic branch, input logic [4:0] rs1,
                                input logic rs1_used, input logic [4:0] rs2,
                                input logic rs2_used, input logic [4:0] rd,
                                input logic taken);
      bus.id_valid        = valid;
      bus.id_ctrl         = ctrl;
      bus.id_branch       = branch;
      bus.id_rs1          = rs1;
      bus.id_rs1_used     = rs1_used;
      bus.id_rs2          = rs2;
      bus.id_rs2_used     = rs2_used;
      bus.id_rd           = rd;
      bus.ex_branch_taken = taken;
      #1;
      checkAgainstModel();
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 20'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Advance one clock and shift the model the same way
   task automatic clockStep();
      stage_t next_ex;
      if (exp_stall || exp_flush) begin
         next_ex = emptyStage();
      end else begin
         next_ex.valid  = bus.id_valid;
         next_ex.ctrl   = bus.id_ctrl;
         next_ex.branch = bus.id_branch;
         next_ex.rs1    = bus.id_rs1;
         next_ex.rs2    = bus.id_rs2;
         next_ex.rd     = bus.id_rd;
      end
      @(posedge clk);
      mdl[2] = mdl[1];
      mdl[1] = mdl[0];
      mdl[0] = next_ex;
      @(negedge clk);
   endtask

   task automatic clearModel();
      for (int i = 0; i < 3; i++) mdl[i] = emptyStage();
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      clearModel();
      rst = 1'b1;
      bus.id_valid = 1'b0; bus.id_ctrl = 20'd0; bus.id_branch = 1'b0;
      bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rs1_used = 1'b0;
      bus.id_rs2_used = 1'b0; bus.id_rd = 5'd0; bus.ex_branch_taken = 1'b0;

      // Reset state
      @(negedge clk);
      applyIdle();
      rst = 1'b0;
      #1;

      // Load-use: lw x5 then add x6,x5,x1
      applyStimulus(1, W_LW, 0, 5'd1, 1, 5'd0, 0, 5'd5, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd5, 1, 5'd1, 1, 5'd6, 0);
      checkOutput("lu_stall", 32'(bus.stall), 32'd1);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd5, 1, 5'd1, 1, 5'd6, 0);
      checkOutput("lu_bubble", 32'(bus.ex_valid), 32'd0);
      checkOutput("lu_stall_clear", 32'(bus.stall), 32'd0);
      clockStep();
      applyIdle();
      checkOutput("lu_fwd_wb", 32'(bus.fwd_a), 32'd2);
      clockStep();

      // Forward priority: MEM beats WB
      applyStimulus(1, W_ADD, 0, 5'd0, 0, 5'd0, 0, 5'd3, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd0, 0, 5'd0, 0, 5'd3, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd3, 1, 5'd3, 1, 5'd7, 0);
      clockStep();
      applyIdle();
      checkOutput("prio_fwd_a", 32'(bus.fwd_a), 32'd1);
      clockStep();

      // x0 never forwards
      applyStimulus(1, W_ADD, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd0, 1, 5'd0, 1, 5'd7, 0);
      clockStep();
      applyIdle();
      checkOutput("x0_fwd_a", 32'(bus.fwd_a), 32'd0);
      clockStep();

      // Taken branch, then not-taken branch
      applyStimulus(1, W_BR, 1, 5'd1, 1, 5'd2, 1, 5'd0, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd1, 1, 5'd2, 1, 5'd9, 1);
      checkOutput("br_flush", 32'(bus.flush), 32'd1);
      checkOutput("br_pc_sel", 32'(bus.pc_sel), 32'd2);
      clockStep();
      applyIdle();
      checkOutput("br_bubble", 32'(bus.ex_valid), 32'd0);
      clockStep();
      applyStimulus(1, W_BR, 1, 5'd1, 1, 5'd2, 1, 5'd0, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd1, 1, 5'd2, 1, 5'd9, 0);
      checkOutput("nt_flush", 32'(bus.flush), 32'd0);
      checkOutput("nt_pc_sel", 32'(bus.pc_sel), 32'd0);
      clockStep();

      // jalr / jal / mret, each flushing for exactly one cycle
      applyStimulus(1, W_JALR, 0, 5'd1, 1, 5'd0, 0, 5'd1, 0);
      clockStep();
      applyIdle();
      checkOutput("jalr_pc_sel", 32'(bus.pc_sel), 32'd1);
      checkOutput("jalr_flush", 32'(bus.flush), 32'd1);
      clockStep();
      applyIdle();
      checkOutput("jalr_flush_end", 32'(bus.flush), 32'd0);
      applyStimulus(1, W_JAL, 0, 5'd0, 0, 5'd0, 0, 5'd1, 0);
      clockStep();
      applyIdle();
      checkOutput("jal_pc_sel", 32'(bus.pc_sel), 32'd3);
      clockStep();
      applyIdle();
      checkOutput("jal_flush_end", 32'(bus.flush), 32'd0);
      applyStimulus(1, W_MRET, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0);
      clockStep();
      applyIdle();
      checkOutput("mret_pc_sel", 32'(bus.pc_sel), 32'd5);
      checkOutput("mret_flush", 32'(bus.flush), 32'd1);
      clockStep();
      applyIdle();
      checkOutput("mret_flush_end", 32'(bus.flush), 32'd0);

      // Redirect with dependent instruction in ID: flush wins
      applyStimulus(1, W_JAL, 0, 5'd0, 0, 5'd0, 0, 5'd5, 0);
      clockStep();
      applyStimulus(1, W_ADD, 0, 5'd5, 1, 5'd5, 1, 5'd6, 0);
      checkOutput("sr_stall", 32'(bus.stall), 32'd0);
      checkOutput("sr_flush", 32'(bus.flush), 32'd1);
      clockStep();
      applyIdle();
      checkOutput("sr_bubble", 32'(bus.ex_valid), 32'd0);

      // Mid-stream asynchronous reset
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, W_ADD, 0, 5'd4, 1, 5'd4, 1, 5'(i + 4), 0);
         clockStep();
      end
      applyStimulus(1, W_ADD, 0, 5'd4, 1, 5'd4, 1, 5'd4, 0);
      rst = 1'b1;
      #1;
      clearModel();
      checkAgainstModel();
      checkOutput("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      checkOutput("rst_mem_ctrl", 32'(bus.mem_ctrl), 32'd0);
      #1;
      rst = 1'b0;
      applyStimulus(1, 20'h12345 & ~20'h00058, 0, 5'd2, 1, 5'd3, 1, 5'd8, 0);
      clockStep();
      applyIdle();
      checkOutput("rst_first_ex", 32'(bus.ex_ctrl), 32'(20'h12345 & ~20'h00058));
      clockStep();

      // Randomized traffic; small register range to provoke hazards
      for (int n = 0; n < 300; n++) begin
         logic [19:0] c;
         c = 20'($urandom);
         if ($urandom_range(0, 3) != 0) c[3] = 1'b0;
         if ($urandom_range(0, 5) != 0) c[4] = 1'b0;
         applyStimulus(1'($urandom_range(0, 4) != 0), c, 1'($urandom),
                       5'($urandom_range(0, 3)), 1'($urandom),
                       5'($urandom_range(0, 3)), 1'($urandom),
                       5'($urandom_range(0, 3)), 1'($urandom));
         clockStep();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
